fwd_scoreboard: RTL and testbench

// - Parametrised forwarding/hazard scoreboard for the LC-3b pipeline; successor to the combinational forwarding mux-select logic.
// - Tracks in-flight destination registers in an internal shift pipe (slot0=EX .. slotDEPTH-1).
// - Resolves per-source forwarding selects at ID and registers them for EX.
// - Generates load-use bubbles for any load latency, and freezes on memory wait.

---
 rtl/fwd_scoreboard.sv | 114 +++++++++++
 tb/tb_fwd_scoreboard.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
`timescale 1ns/1ps
// Forwarding/hazard scoreboard for the LC-3b pipeline: tracks in-flight destinations,
// resolves per-source operand selects, inserts load-use bubbles. Optional FWD_PERF_CNT_EN adds stall counters.
module fwd_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LD_AVAIL = 2,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int SEL_W   = $clog2(DEPTH + 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_W-1:0]           id_dest,
  input  logic                       id_we,
  input  logic                       id_ld,
  input  logic                       mem_stall,
  input  logic                       flush,
  output logic                       id_stall,
  output logic                       ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]   ex_sel,
  output logic [1:0]                 fsm_state
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]                ld_stall_cnt,
  output logic [31:0]                mem_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LD_BUBBLE = 2'b01,
    MEM_WAIT  = 2'b10
  } state_t;

  state_t                 state;
  logic [DEPTH-1:0]       slot_valid;
  logic [DEPTH-1:0]       slot_we;
  logic [DEPTH-1:0]       slot_ld;
  logic [REG_W-1:0]       slot_dest [DEPTH];

  logic [NUM_SRC*SEL_W-1:0] id_sel;
  logic [NUM_SRC-1:0]       src_hz;
  logic                     hazard;
  logic                     push;

  // Scan oldest to youngest so the youngest matching producer overrides any older one.
  always_comb begin
    id_sel = '0;
    src_hz = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        for (int s = DEPTH - 1; s >= 0; s--) begin
          if (slot_valid[s] && slot_we[s] && (slot_dest[s] == id_src[i*REG_W +: REG_W])) begin
            id_sel[i*SEL_W +: SEL_W] = SEL_W'(s + 1);
            src_hz[i]                = slot_ld[s] && ((s + 1) < LD_AVAIL);
          end
        end
      end
    end
  end

  // Handshake: the ID instruction is consumed on a rising edge where
  // id_valid & ~id_stall & ~flush; otherwise ID must hold and a bubble enters EX.
  assign hazard    = id_valid && (|src_hz);
  assign id_stall  = hazard || mem_stall;
  assign push      = id_valid && !id_stall && !flush;
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      slot_valid <= '0;
      slot_we    <= '0;
      slot_ld    <= '0;
      for (int s = 0; s < DEPTH; s++) slot_dest[s] <= '0;
      ex_valid   <= 1'b0;
      ex_sel     <= '0;
    end else begin
      if (mem_stall)             state <= MEM_WAIT;
      else if (hazard && !flush) state <= LD_BUBBLE;
      else                       state <= RUN;

      if (!mem_stall) begin
        slot_valid <= {slot_valid[DEPTH-2:0], push};
        slot_we    <= {slot_we[DEPTH-2:0], id_we};
        slot_ld    <= {slot_ld[DEPTH-2:0], id_ld};
        for (int s = DEPTH - 1; s > 0; s--) slot_dest[s] <= slot_dest[s-1];
        slot_dest[0] <= id_dest;
        ex_valid     <= push;
        ex_sel       <= push ? id_sel : '0;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Counters saturate rather than wrap so long runs never read as low stall counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_stall_cnt  <= '0;
      mem_stall_cnt <= '0;
    end else begin
      if ((state == LD_BUBBLE) && (ld_stall_cnt != '1))
        ld_stall_cnt <= ld_stall_cnt + 32'd1;
      if ((state == MEM_WAIT) && (mem_stall_cnt != '1))
        mem_stall_cnt <= mem_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
`timescale 1ns/1ps
// Directed bench for fwd_scoreboard: forwarding distances, load-use bubble,
// memory freeze, flush and mid-stream reset with hand-computed expectations.
module tb_fwd_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_src;
  logic [1:0] id_src_used;
  logic [2:0] id_dest;
  logic       id_we;
  logic       id_ld;
  logic       mem_stall;
  logic       flush;
  logic       id_stall;
  logic       ex_valid;
  logic [5:0] ex_sel;
  logic [1:0] fsm_state;

  int checks   = 0;
  int failures = 0;

  fwd_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dest     (id_dest),
    .id_we       (id_we),
    .id_ld       (id_ld),
    .mem_stall   (mem_stall),
    .flush       (flush),
    .id_stall    (id_stall),
    .ex_valid    (ex_valid),
    .ex_sel      (ex_sel),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                        input logic [1:0] used, input logic [2:0] d,
                        input logic we, input logic ld);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_dest     = d;
    id_we       = we;
    id_ld       = ld;
  endtask

  task automatic nop();
    set_id(1'b0, 3'd0, 3'd0, 2'b00, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_stall = 1'b0;
    flush     = 1'b0;
    nop();
    #2;
    check("rst_id_stall", {31'd0, id_stall}, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_sel",   {26'd0, ex_sel},   32'd0);
    check("rst_fsm",      {30'd0, fsm_state}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ADD R1 ; ADD R2,R1,R3 back-to-back
    set_id(1'b1, 3'd2, 3'd3, 2'b11, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 3'd3, 2'b11, 3'd2, 1'b1, 1'b0);
    #1;
    check("b2b_id_stall", {31'd0, id_stall}, 32'd0);
    tick();
    check("b2b_ex_sel",   {26'd0, ex_sel},   {26'd0, 3'd0, 3'd1});
    check("b2b_ex_valid", {31'd0, ex_valid}, 32'd1);
    drain();

    // distance 2, 3 and 4 (retired -> regfile)
    for (int n = 1; n <= 3; n++) begin
      set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
      tick();
      nop();
      repeat (n) tick();
      set_id(1'b1, 3'd1, 3'd3, 2'b11, 3'd2, 1'b1, 1'b0);
      tick();
      case (n)
        1:       check("dist2_ex_sel", {26'd0, ex_sel}, {26'd0, 3'd0, 3'd2});
        2:       check("dist3_ex_sel", {26'd0, ex_sel}, {26'd0, 3'd0, 3'd3});
        default: check("dist4_ex_sel", {26'd0, ex_sel}, {26'd0, 3'd0, 3'd0});
      endcase
      drain();
    end

    // LDR R1 ; ADD R3,R1,R1 -> one bubble
    set_id(1'b1, 3'd6, 3'd0, 2'b01, 3'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd1, 3'd1, 2'b11, 3'd3, 1'b1, 1'b0);
    #1;
    check("ldu_id_stall_1", {31'd0, id_stall}, 32'd1);
    check("ldu_fsm_0",      {30'd0, fsm_state}, 32'd0);
    tick();
    check("ldu_id_stall_2", {31'd0, id_stall}, 32'd0);
    check("ldu_fsm_1",      {30'd0, fsm_state}, 32'd1);
    check("ldu_bubble",     {31'd0, ex_valid}, 32'd0);
    tick();
    check("ldu_ex_sel",     {26'd0, ex_sel},   {26'd0, 3'd2, 3'd2});
    check("ldu_ex_valid",   {31'd0, ex_valid}, 32'd1);
    check("ldu_fsm_2",      {30'd0, fsm_state}, 32'd0);
    drain();

    // ADD R1 ; ADD R1 ; ADD R4,R1,R5 -> youngest wins
    set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 3'd5, 2'b11, 3'd4, 1'b1, 1'b0);
    tick();
    check("young_ex_sel", {26'd0, ex_sel}, {26'd0, 3'd0, 3'd1});
    // source not used -> regfile
    set_id(1'b1, 3'd4, 3'd1, 2'b00, 3'd2, 1'b1, 1'b0);
    tick();
    check("unused_ex_sel",   {26'd0, ex_sel},   32'd0);
    check("unused_ex_valid", {31'd0, ex_valid}, 32'd1);
    // producer with we=0 -> no forward
    set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd7, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd7, 3'd0, 2'b01, 3'd3, 1'b1, 1'b0);
    tick();
    check("nowe_ex_sel", {26'd0, ex_sel}, 32'd0);
    drain();

    // ADD R6 ; LDR R1,R6 ; ADD R3,R1,R1 with 5 cycles of mem_stall
    set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd6, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd6, 3'd0, 2'b01, 3'd1, 1'b1, 1'b1);
    tick();
    check("ms_pre_ex_sel", {26'd0, ex_sel}, {26'd0, 3'd0, 3'd1});
    set_id(1'b1, 3'd1, 3'd1, 2'b11, 3'd3, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    check("ms_id_stall", {31'd0, id_stall}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("ms_fsm",      {30'd0, fsm_state}, 32'd2);
      check("ms_ex_valid", {31'd0, ex_valid},  32'd1);
      check("ms_ex_sel",   {26'd0, ex_sel},    {26'd0, 3'd0, 3'd1});
    end
    mem_stall = 1'b0;
    #1;
    check("ms_rel_id_stall", {31'd0, id_stall}, 32'd1);
    tick();
    check("ms_rel_fsm",    {30'd0, fsm_state}, 32'd1);
    check("ms_rel_bubble", {31'd0, ex_valid},  32'd0);
    tick();
    check("ms_rel_ex_sel", {26'd0, ex_sel},    {26'd0, 3'd2, 3'd2});
    check("ms_rel_fsm_2",  {30'd0, fsm_state}, 32'd0);
    drain();

    // flush with dependent instruction in ID
    set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 3'd0, 2'b01, 3'd2, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_ex_sel",   {26'd0, ex_sel},   32'd0);
    set_id(1'b1, 3'd1, 3'd0, 2'b01, 3'd5, 1'b1, 1'b0);
    tick();
    check("flush_next_sel", {26'd0, ex_sel}, {26'd0, 3'd0, 3'd2});
    drain();

    // async reset while a load-use stall is pending
    set_id(1'b1, 3'd0, 3'd0, 2'b00, 3'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd1, 3'd0, 2'b01, 3'd2, 1'b1, 1'b0);
    #1;
    check("prerst_id_stall", {31'd0, id_stall}, 32'd1);
    check("prerst_ex_valid", {31'd0, ex_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_id_stall", {31'd0, id_stall},  32'd0);
    check("arst_ex_valid", {31'd0, ex_valid},  32'd0);
    check("arst_ex_sel",   {26'd0, ex_sel},    32'd0);
    check("arst_fsm",      {30'd0, fsm_state}, 32'd0);
    tick();
    rst_n = 1'b1;
    nop();
    tick();

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
